// File: rtl/axi_llc_way_arbiter.sv
// Round-robin arbiter with burst locking in front of the LLC data way request port.
// A granted requester keeps the port until it hands over a beat flagged last.
module axi_llc_way_arbiter #(
   parameter int unsigned NumReq   = 4,
   parameter type         way_inp_t = logic,
   parameter int unsigned IdxWidth = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  way_inp_t            req_i [NumReq],
   input  logic [NumReq-1:0]   req_last_i,
   input  logic [NumReq-1:0]   req_valid_i,
   output logic [NumReq-1:0]   req_ready_o,
   output way_inp_t            way_inp_o,
   output logic                way_inp_valid_o,
   input  logic                way_inp_ready_i,
   output logic [IdxWidth-1:0] gnt_idx_o,
   output logic                locked_o,
   output logic [15:0]         beat_cnt_o
);

   localparam int unsigned CntWidth = 16;
   localparam logic [CntWidth-1:0] CntMax = '1;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_e;

   state_e                r_state;
   state_e                w_state_d;
   logic [IdxWidth-1:0]   r_lock_idx;
   logic [IdxWidth-1:0]   w_lock_idx_d;
   logic [IdxWidth-1:0]   r_rr;
   logic [IdxWidth-1:0]   w_rr_d;
   logic [CntWidth-1:0]   r_beat_cnt;
   logic [CntWidth-1:0]   w_beat_cnt_d;

   logic [IdxWidth-1:0]   w_scan_idx;
   logic                  w_found;
   int unsigned           w_sum;
   logic [IdxWidth-1:0]   w_cand;
   logic [IdxWidth-1:0]   w_gnt;
   logic                  w_valid;
   logic                  w_last;

   // Explicit wrap so non-power-of-two requester counts stay in range.
   function automatic logic [IdxWidth-1:0] inc_wrap(input logic [IdxWidth-1:0] v);
      if (v == IdxWidth'(NumReq - 1)) begin
         return '0;
      end
      return v + IdxWidth'(1);
   endfunction

   // First valid requester scanning upward from the round-robin pointer.
   always_comb begin
      w_scan_idx = r_rr;
      w_found    = 1'b0;
      w_sum      = 0;
      w_cand     = '0;
      for (int unsigned i = 0; i < NumReq; i++) begin
         w_sum = 32'(r_rr) + i;
         if (w_sum >= NumReq) begin
            w_sum = w_sum - NumReq;
         end
         w_cand = IdxWidth'(w_sum);
         if (!w_found && req_valid_i[w_cand]) begin
            w_found    = 1'b1;
            w_scan_idx = w_cand;
         end
      end
   end

   assign w_gnt   = (r_state == LOCK) ? r_lock_idx : w_scan_idx;
   assign w_valid = req_valid_i[w_gnt];
   assign w_last  = req_last_i[w_gnt];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_lock_idx <= '0;
         r_rr       <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state    <= w_state_d;
         r_lock_idx <= w_lock_idx_d;
         r_rr       <= w_rr_d;
         r_beat_cnt <= w_beat_cnt_d;
      end
   end

   // Next state: a stalled first beat locks too, so the payload stays put.
   always_comb begin
      w_state_d    = r_state;
      w_lock_idx_d = r_lock_idx;
      w_rr_d       = r_rr;
      w_beat_cnt_d = r_beat_cnt;
      unique case (r_state)
         IDLE: begin
            if (w_valid) begin
               if (way_inp_ready_i && w_last) begin
                  w_rr_d = inc_wrap(w_gnt);
               end else begin
                  w_state_d    = LOCK;
                  w_lock_idx_d = w_gnt;
                  if (way_inp_ready_i) begin
                     w_beat_cnt_d = CntWidth'(1);
                  end
               end
            end
         end
         LOCK: begin
            if (w_valid && way_inp_ready_i) begin
               if (w_last) begin
                  w_state_d    = IDLE;
                  w_rr_d       = inc_wrap(r_lock_idx);
                  w_beat_cnt_d = '0;
               end else if (r_beat_cnt != CntMax) begin
                  w_beat_cnt_d = r_beat_cnt + CntWidth'(1);
               end
            end
         end
         default: w_state_d = IDLE;
      endcase
   end

   // Zero-latency pass-through of the granted requester.
   always_comb begin
      req_ready_o        = '0;
      req_ready_o[w_gnt] = way_inp_ready_i;
      way_inp_o          = req_i[w_gnt];
      way_inp_valid_o    = w_valid;
      gnt_idx_o          = w_gnt;
      locked_o           = (r_state == LOCK);
      beat_cnt_o         = r_beat_cnt;
   end

endmodule

// File: doc/axi_llc_way_arbiter.md
# axi_llc_way_arbiter

Shares the single data-storage way request port among the LLC units that access it: refill, eviction, read and write. It does round-robin arbitration with burst locking. A requester that gets the port keeps it until it transfers a beat flagged `last`, so a multi-beat line refill or eviction is never interleaved with another unit. The block sits directly in front of the data way; its output handshake follows the stream rules the way storage expects.

## Interface
Parameters:
- `NumReq`, 4: number of requesters; must be ≥ 2. Index 0 is the refill unit, 1 eviction, 2 read, 3 write.
- `way_inp_t`, logic: payload type of a way request.
- `IdxWidth`, `$clog2(NumReq)`: width of the grant index. Derived; do not override.

Ports:
- `clk_i`, in, 1: clock, rising-edge.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `req_i`, in, `NumReq × way_inp_t`: request payload per requester.
- `req_last_i`, in, `NumReq`: the beat is the last of its burst; single-beat requests drive 1.
- `req_valid_i`, in, `NumReq`: request valid per requester.
- `req_ready_o`, out, `NumReq`: request accepted per requester.
- `way_inp_o`, out, `way_inp_t`: payload of the granted requester.
- `way_inp_valid_o`, out, 1: output request valid.
- `way_inp_ready_i`, in, 1: data way accepts the request.
- `gnt_idx_o`, out, `IdxWidth`: index of the currently granted requester.
- `locked_o`, out, 1: a burst is in progress or an output beat is stalled.
- `beat_cnt_o`, out, 16: beats transferred in the current burst. Saturates at 0xFFFF.

## Operation
- State machine with two states.
  - IDLE: no requester owns the port.
  - LOCK: requester `lock_idx_q` owns the port.
- Registers:
  - `state_q`
  - `lock_idx_q`
  - `rr_q`: the requester with highest priority in IDLE.
  - `beat_cnt_q`
- Selection in IDLE:
  - Grant the first valid requester found scanning `rr_q, rr_q+1, …`, modulo `NumReq`.
  - With no valid requester, `gnt_idx_o = rr_q` and `way_inp_valid_o = 0`.
- Selection in LOCK: the grant is `lock_idx_q` regardless of the other valids.
- Output path:
  - `way_inp_o = req_i[gnt]`
  - `way_inp_valid_o = req_valid_i[gnt]`
  - `req_ready_o[gnt] = way_inp_ready_i`
  - All other `req_ready_o` bits are 0.
- Transitions from IDLE:
  - Output valid and ready with `last = 1`: stay in IDLE; `rr_q ← gnt+1 mod NumReq`.
  - Output valid and ready with `last = 0`: go to LOCK; `lock_idx_q ← gnt`; `beat_cnt_q ← 1`.
  - Output valid and not ready: go to LOCK; `lock_idx_q ← gnt`; `beat_cnt_q` unchanged (0). This keeps the payload stable under backpressure, because a requester must not drop valid.
- Transitions from LOCK:
  - Handshake with `last = 1`: go to IDLE; `rr_q ← lock_idx_q+1 mod NumReq`; `beat_cnt_q ← 0`.
  - Handshake with `last = 0`: stay in LOCK; `beat_cnt_q` increments, saturating.
  - No handshake: hold.
- `locked_o = (state_q == LOCK)`.
- `beat_cnt_o = beat_cnt_q`.
- The modulo wrap from `NumReq-1` to 0 is explicit; it is not a power-of-two truncation.

## Timing
- Reset values:
  - `state_q = IDLE`, `rr_q = 0`, `lock_idx_q = 0`, `beat_cnt_q = 0`.
  - Therefore `locked_o = 0`, `beat_cnt_o = 0`, `gnt_idx_o = 0`.
  - `way_inp_valid_o = 0` and `req_ready_o = 0` while all `req_valid_i = 0`.
- Latency: zero cycles. Valid, payload and ready are combinational pass-through for the granted index. The only combinational path from `way_inp_ready_i` is to `req_ready_o`.
- All state updates happen on the clock edge on which the handshake (or stall) is sampled.
- Simultaneous events:
  - A new request arriving during LOCK waits; there is no preemption.
  - When a `last` handshake ends a burst, the next grant is evaluated in the following cycle from the updated `rr_q`. There is one IDLE cycle only if nothing is valid.
- Reset mid-burst: all state clears immediately. The next grant starts from index 0.
- Deassertion of a granted valid before ready violates protocol upstream. In LOCK the arbiter still holds the grant; there is no recovery logic.
- Fairness: every valid requester is granted within `NumReq-1` completed bursts.

## Test plan
- Reset, all valids low → `way_inp_valid_o = 0`, `locked_o = 0`, `gnt_idx_o = 0`, `beat_cnt_o = 0`.
- Requesters 0–3 valid, all single-beat (`last = 1`), ready held 1 → grants in the order 0, 1, 2, 3, 0 on consecutive cycles.
- Requester 0 issues 4 beats (`last` on beat 4) while 2 is valid, ready = 1:
  - Grant stays 0 for 4 cycles.
  - `beat_cnt_o` reads 1, 2, 3 during the burst.
  - Requester 2 is granted in cycle 5.
  - `rr_q` becomes 1.
- Requester 1 valid with ready = 0 for 3 cycles while 0 becomes valid on cycle 1 → `locked_o = 1`, grant stays 1, payload stable. On ready → requester 1 transfers, then requester 2/3/0 are granted per `rr_q = 2`.
- Assert `rst_ni = 0` during beat 2 of a burst from requester 3 → `locked_o` drops asynchronously; after release, valid requesters 1 and 3 give grant 1.
- Burst of 70000 beats from requester 1 → `beat_cnt_o` saturates at 0xFFFF; after `last`, `beat_cnt_o = 0` and state returns to IDLE.
